bdcmotor_channel_n: RTL

BDCMOTOR_CHANNEL_N -- requirements
Module: bdcmotor_channel_n

---
 rtl/bdcmotor_pkg.sv | 26 ++
 rtl/bdcmotor_channel_n_quad_tach_n.sv | 81 ++++++++
 rtl/bdcmotor_channel_n.sv | 108 ++++++++++
 3 files changed

// File: rtl/bdcmotor_pkg.sv
// rtl/bdcmotor_pkg.sv - shared defaults, dead-time FSM states and quadrature step codes
package bdcmotor_pkg;

  localparam int PWM_W_DEF      = 8;
  localparam int CNT_W_DEF      = 16;
  localparam int FILT_DEPTH_DEF = 3;
  localparam int DT_W_DEF       = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_GAP} dt_state_e;

  localparam logic [1:0] STEP_NONE = 2'd0;
  localparam logic [1:0] STEP_UP   = 2'd1;
  localparam logic [1:0] STEP_DOWN = 2'd2;
  localparam logic [1:0] STEP_ERR  = 2'd3;

  // Forward Gray order 00->01->11->10 means next = {prev[0], ~prev[1]}.
  function automatic logic [1:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] step;
    if (prev == cur)                    step = STEP_NONE;
    else if ((prev ^ cur) == 2'b11)     step = STEP_ERR;
    else if (cur == {prev[0], ~prev[1]}) step = STEP_UP;
    else                                step = STEP_DOWN;
    return step;
  endfunction

endpackage

// File: rtl/bdcmotor_channel_n_quad_tach_n.sv
// rtl/bdcmotor_channel_n_quad_tach_n.sv - tach filter, 4x quadrature decoder, position counter, freeze snapshot
module quad_tach_n
  import bdcmotor_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FILT_DEPTH = FILT_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             filterce,
  input  logic             freeze,
  input  logic             invphase,
  input  logic [1:0]       tach,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             tacherr
);

  logic [FILT_DEPTH-1:0] sha_q, sha_d, shb_q, shb_d;
  logic [1:0]            filt_q, filt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, snap_q, snap_d;
  logic                  dir_q, dir_d, err_q, err_d, frozen_q;
  logic [1:0]            step;

  always_comb begin
    sha_d = sha_q;
    shb_d = shb_q;
    if (filterce) begin
      sha_d = {sha_q[FILT_DEPTH-2:0], tach[0]};
      shb_d = {shb_q[FILT_DEPTH-2:0], tach[1]};
    end
    filt_d = filt_q;
    if (&sha_q)       filt_d[0] = 1'b1;
    else if (~|sha_q) filt_d[0] = 1'b0;
    if (&shb_q)       filt_d[1] = 1'b1;
    else if (~|shb_q) filt_d[1] = 1'b0;

    step = quad_step(filt_q, filt_d);
    if (invphase && (step == STEP_UP))        step = STEP_DOWN;
    else if (invphase && (step == STEP_DOWN)) step = STEP_UP;

    cnt_d = cnt_q;
    dir_d = dir_q;
    err_d = err_q;
    case (step)
      STEP_UP:   begin cnt_d = cnt_q + 1'b1; dir_d = 1'b1; end
      STEP_DOWN: begin cnt_d = cnt_q - 1'b1; dir_d = 1'b0; end
      STEP_ERR:  err_d = 1'b1;
      default:   ;
    endcase
    // Snapshot tracks the counter until freeze is registered, then holds.
    snap_d = frozen_q ? snap_q : cnt_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sha_q    <= '0;
      shb_q    <= '0;
      filt_q   <= '0;
      cnt_q    <= '0;
      snap_q   <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      frozen_q <= 1'b0;
    end else begin
      sha_q    <= sha_d;
      shb_q    <= shb_d;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      frozen_q <= freeze;
    end
  end

  assign count   = frozen_q ? snap_q : cnt_q;
  assign dir     = dir_q;
  assign tacherr = err_q;

endmodule

// File: rtl/bdcmotor_channel_n.sv
// rtl/bdcmotor_channel_n.sv - brushed DC motor channel: PWM, current clip, mode, dead-time, tach
module bdcmotor_channel_n
  import bdcmotor_pkg::*;
#(
  parameter int PWM_W      = PWM_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FILT_DEPTH = FILT_DEPTH_DEF,
  parameter int DT_W       = DT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             filterce,
  input  logic             pwmcntce,
  input  logic             pwmldce,
  input  logic             freeze,
  input  logic             invphase,
  input  logic             invertpwm,
  input  logic             enablepwm,
  input  logic             run,
  input  logic             currentlimit,
  input  logic [DT_W-1:0]  deadtime,
  input  logic [1:0]       tach,
  input  logic [PWM_W-1:0] wrtdata,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             tacherr,
  output logic [1:0]       pwmout
);

  // Last counter value of a period is MAX-1 = 2^PWM_W - 2.
  localparam logic [PWM_W-1:0] PWM_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

  logic [PWM_W-1:0] pwmcnt_q, pwmcnt_d, pend_q, pend_d, duty_q, duty_d;
  logic             clip_q, clip_d, period_start, hi_ideal;
  logic [1:0]       req, cur, pair_q, pair_d, tgt_q, tgt_d;
  logic [DT_W-1:0]  gap_q, gap_d;
  dt_state_e        state_q, state_d;

  quad_tach_n #(.CNT_W(CNT_W), .FILT_DEPTH(FILT_DEPTH)) u_tach (
    .clk(clk), .rstn(rstn), .filterce(filterce), .freeze(freeze), .invphase(invphase),
    .tach(tach), .count(count), .dir(dir), .tacherr(tacherr)
  );

  always_comb begin
    period_start = pwmcntce && (pwmcnt_q == PWM_LAST);
    pwmcnt_d     = pwmcnt_q;
    if (pwmcntce) pwmcnt_d = period_start ? '0 : pwmcnt_q + 1'b1;
    pend_d   = pwmldce ? wrtdata : pend_q;
    duty_d   = period_start ? pend_q : duty_q;
    clip_d   = currentlimit | (clip_q & ~period_start);
    hi_ideal = (pwmcnt_q < duty_q) && !clip_q && !currentlimit;

    if (!enablepwm) req = 2'b00;
    else if (!run)  req = 2'b10;
    else            req = {~hi_ideal, hi_ideal};

    // While in GAP the pending target is what counts as the current request.
    cur     = (state_q == ST_GAP) ? tgt_q : pair_q;
    state_d = state_q;
    tgt_d   = tgt_q;
    gap_d   = gap_q;
    if (req == 2'b00) begin
      state_d = ST_IDLE;
    end else if (req != cur) begin
      tgt_d = req;
      if (deadtime == '0) begin
        state_d = (req == 2'b01) ? ST_HIGH : ST_LOW;
      end else begin
        state_d = ST_GAP;
        gap_d   = deadtime;
      end
    end else if (state_q == ST_GAP) begin
      if (gap_q <= DT_W'(1)) state_d = (tgt_q == 2'b01) ? ST_HIGH : ST_LOW;
      else                   gap_d   = gap_q - 1'b1;
    end

    case (state_d)
      ST_HIGH: pair_d = 2'b01;
      ST_LOW:  pair_d = 2'b10;
      default: pair_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwmcnt_q <= '0;
      pend_q   <= '0;
      duty_q   <= '0;
      clip_q   <= 1'b0;
      state_q  <= ST_IDLE;
      pair_q   <= 2'b00;
      tgt_q    <= 2'b00;
      gap_q    <= '0;
    end else begin
      pwmcnt_q <= pwmcnt_d;
      pend_q   <= pend_d;
      duty_q   <= duty_d;
      clip_q   <= clip_d;
      state_q  <= state_d;
      pair_q   <= pair_d;
      tgt_q    <= tgt_d;
      gap_q    <= gap_d;
    end
  end

  assign pwmout = pair_q ^ {2{invertpwm}};

endmodule
